// File: rtl/sliding_window_3x3_pkg.sv
// Shared definitions for the 3x3 neighbourhood generator: window element
// indices (k = 3*row + col) and the window bus width helper.
package sliding_window_3x3_pkg;

    localparam int K_TL = 0;
    localparam int K_TC = 1;
    localparam int K_TR = 2;
    localparam int K_ML = 3;
    localparam int K_MC = 4;
    localparam int K_MR = 5;
    localparam int K_BL = 6;
    localparam int K_BC = 7;
    localparam int K_BR = 8;

    localparam int WINDOW_ELEMS = 9;

    function automatic int window_bus_width(input int pixel_depth);
        return WINDOW_ELEMS * pixel_depth;
    endfunction

endpackage

// File: rtl/sliding_window_3x3_line_buffer.sv
// Row delay line: O_DATA is the pixel accepted P_DEPTH enables earlier.
// Storage is intentionally unreset; the consumer never uses stale rows.
module line_buffer #(
    parameter int P_DEPTH = 640,
    parameter int P_WIDTH = 8
) (
    input  logic               I_CLK,
    input  logic               I_EN,
    input  logic [P_WIDTH-1:0] I_DATA,
    output logic [P_WIDTH-1:0] O_DATA
);

    logic [P_WIDTH-1:0] tap_reg [P_DEPTH];

    always_ff @(posedge I_CLK) begin
        if (I_EN) begin
            tap_reg[0] <= I_DATA;
            for (int i = 1; i < P_DEPTH; i++) begin
                tap_reg[i] <= tap_reg[i-1];
            end
        end
    end

    assign O_DATA = tap_reg[P_DEPTH-1];

endmodule

// File: rtl/sliding_window_3x3.sv
// Streaming 3x3 window generator: two row delay lines feed a shifting 3x3
// register array; a window is emitted only when fully inside the image.
module sliding_window_3x3
    import sliding_window_3x3_pkg::*;
#(
    parameter int P_PIXEL_DEPTH  = 8,
    parameter int P_IMAGE_WIDTH  = 640,
    parameter int P_IMAGE_HEIGHT = 480
) (
    input  logic                                        I_CLK,
    input  logic                                        I_RESET,
    input  logic                                        I_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]                    I_PIXEL,
    output logic [window_bus_width(P_PIXEL_DEPTH)-1:0]  O_WINDOW,
    output logic                                        O_VALID,
    output logic                                        O_FRAME_DONE
);

    localparam int COL_W = $clog2(P_IMAGE_WIDTH);
    localparam int ROW_W = $clog2(P_IMAGE_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_FULL = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_FULL = ROW_W'(2);

    logic [COL_W-1:0]         col_reg;
    logic [ROW_W-1:0]         row_reg;
    logic [P_PIXEL_DEPTH-1:0] win_reg [WINDOW_ELEMS];
    logic                     valid_reg;
    logic                     done_reg;

    logic                     accept;
    logic                     emit;
    logic                     last_pixel;
    logic [P_PIXEL_DEPTH-1:0] row_above1;
    logic [P_PIXEL_DEPTH-1:0] row_above2;

    // A pixel arriving together with reset is dropped, so the delay lines hold too.
    assign accept     = I_VALID & ~I_RESET;
    assign emit       = (row_reg >= ROW_FIRST_FULL) && (col_reg >= COL_FIRST_FULL);
    assign last_pixel = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    line_buffer #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (P_PIXEL_DEPTH)
    ) u_lb1 (
        .I_CLK  (I_CLK),
        .I_EN   (accept),
        .I_DATA (I_PIXEL),
        .O_DATA (row_above1)
    );

    line_buffer #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (P_PIXEL_DEPTH)
    ) u_lb2 (
        .I_CLK  (I_CLK),
        .I_EN   (accept),
        .I_DATA (row_above1),
        .O_DATA (row_above2)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            col_reg   <= '0;
            row_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            for (int i = 0; i < WINDOW_ELEMS; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            if (I_VALID) begin
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end

                // Oldest column falls off the left; the new column enters on the right.
                win_reg[K_TL] <= win_reg[K_TC];
                win_reg[K_TC] <= win_reg[K_TR];
                win_reg[K_TR] <= row_above2;
                win_reg[K_ML] <= win_reg[K_MC];
                win_reg[K_MC] <= win_reg[K_MR];
                win_reg[K_MR] <= row_above1;
                win_reg[K_BL] <= win_reg[K_BC];
                win_reg[K_BC] <= win_reg[K_BR];
                win_reg[K_BR] <= I_PIXEL;

                valid_reg <= emit;
                done_reg  <= emit && last_pixel;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WINDOW_ELEMS; gi++) begin : g_window_bus
            assign O_WINDOW[gi*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = win_reg[gi];
        end
    endgenerate

    assign O_VALID      = valid_reg;
    assign O_FRAME_DONE = done_reg;

endmodule

// File: doc/sliding_window_3x3.md
# sliding_window_3x3

Streaming 3x3 neighbourhood generator for the edge-detection datapath. It sits directly downstream of the grayscale converter and consumes one grayscale pixel per accepted cycle in raster order. It buffers the two previous image rows and emits a complete 3x3 window of grayscale pixels to the Sobel gradient stage. It emits a window only for pixels whose full neighbourhood lies inside the image, so no border padding is applied.

## Interface
Parameters:
- P_PIXEL_DEPTH, 8: grayscale pixel width in bits.
- P_IMAGE_WIDTH, 640: pixels per row. Must be ≥ 3.
- P_IMAGE_HEIGHT, 480: rows per frame. Must be ≥ 3.

Ports:
- I_CLK  input  1  clock; all logic on rising edge.
- I_RESET  input  1  reset, synchronous, active-high.
- I_VALID  input  1  I_PIXEL carries the next raster-order pixel this cycle.
- I_PIXEL  input  P_PIXEL_DEPTH  grayscale pixel.
- O_WINDOW  output  9*P_PIXEL_DEPTH  3x3 window, registered.
  - Element k = 3*r + c occupies bits [k*P_PIXEL_DEPTH +: P_PIXEL_DEPTH].
  - r=0 is the top (oldest) row; c=0 is the left (oldest) column.
- O_VALID  output  1  O_WINDOW holds a new window this cycle. Single-cycle qualifier.
- O_FRAME_DONE  output  1  one-cycle pulse, registered with the window of the last frame pixel.

## Operation
- Counters q_col (0..P_IMAGE_WIDTH-1) and q_row (0..P_IMAGE_HEIGHT-1) give the raster position of the next accepted pixel.
  - Widths are $clog2 of the respective parameter.
  - Both counters advance only when I_VALID=1.
- Column wrap: at q_col = W-1, q_col goes to 0 and q_row increments.
- Frame wrap: at (H-1, W-1), both counters go to 0. The next accepted pixel starts a new frame with no gap cycle.
- Two line buffers, each P_IMAGE_WIDTH deep by P_PIXEL_DEPTH wide, FIFO-like, advancing only on I_VALID:
  - LB1 input is I_PIXEL; its output is the pixel one row above.
  - LB2 input is LB1's output; its output is the pixel two rows above.
- Window column shift on I_VALID:
  - column 0 ← column 1;
  - column 1 ← column 2;
  - column 2 ← {LB2 out (r=0), LB1 out (r=1), I_PIXEL (r=2)}.
- Emit condition: an accepted pixel at (row, col) with row ≥ 2 and col ≥ 2.
  - O_VALID=1 on the next cycle.
  - The window is centred on (row-1, col-1).
  - Each frame produces exactly (H-2)*(W-2) windows.
- Pixels with col < 2 never produce a window, so a window never straddles a row boundary.
- Line-buffer storage has no reset. Stale contents cannot reach an emitted window: the row ≥ 2 condition guarantees both buffered rows belong to the current frame.
- No backpressure: the consumer must accept every O_VALID cycle.

## Timing
- Reset values: O_WINDOW=0, O_VALID=0, O_FRAME_DONE=0, q_col=0, q_row=0. The internal window registers reset to 0.
- Latency: 1 cycle from the accepting I_VALID edge to O_VALID.
- I_VALID=0 cycle: nothing advances, O_VALID=0 next cycle, and O_WINDOW holds its last value.
- O_FRAME_DONE asserts in the same cycle as the O_VALID of the window centred on (H-2, W-2).
- Reset mid-frame: counters return to 0, and the next accepted pixel is (0,0). Reset has priority over I_VALID in the same cycle; that pixel is dropped.
- Throughput: one pixel per cycle sustained.

## Structure
- Shared package holds:
  - the window element index constants (K_TL..K_BR, 0..8);
  - the helper for the window bus width (9*P_PIXEL_DEPTH).
- One sub-module, line_buffer:
  - parameterised depth and width, with I_CLK, I_EN, I_DATA and O_DATA;
  - shift register or circular RAM with a single read/write pointer;
  - instantiated twice.
- The top level contains the counters, the emit logic and the window registers.

## Test plan
Use P_IMAGE_WIDTH=5, P_IMAGE_HEIGHT=4, with pixel value 16*row + col.

- **Reset:** hold I_RESET 3 cycles with random I_VALID/I_PIXEL → O_VALID=0, O_FRAME_DONE=0, O_WINDOW=0 throughout.
- **Continuous frame:** 20 pixels with I_VALID=1 →
  - exactly 6 O_VALID pulses;
  - the first arrives the cycle after pixel (2,2), with elements 0..8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22;
  - the last window is centred on 0x23, and O_FRAME_DONE coincides with it.
- **Bubbles:** same frame with I_VALID toggling 1,0,1,0 → the same 6 windows in the same order, no O_VALID during gaps, O_WINDOW stable during gaps.
- **Back-to-back frames:** 40 contiguous pixels, second frame values +0x80 →
  - 12 windows and 2 O_FRAME_DONE pulses;
  - the first window of frame 2 is 0x80,0x81,0x82,0x90,… with no frame-1 data.
- **Reset mid-frame:** 7 pixels, a 1-cycle reset, then a full frame → exactly 6 windows, all matching the continuous-frame expectations.
- **Row wrap:** continuous frame → no O_VALID following any pixel with col 0 or 1.
